// File: rtl/wb_stage_if.sv
// LSU opcode type and the memory-stage / register-file bundle seen by wb_stage.
// The slave modport is the write-back stage's view; master is the surrounding pipeline.
package wb_stage_pkg;
    typedef enum logic {
        LSU_OP_LD = 1'b0,
        LSU_OP_ST = 1'b1
    } lsu_op_e;
endpackage

interface wb_stage_if #(
    parameter int TAG_WIDTH = 4,
    parameter int INSTRET_W = 64
);
    import wb_stage_pkg::*;

    logic                 rd_wr_en_wb;
    logic [TAG_WIDTH-1:0] rd_wr_tag_wb;
    logic [4:0]           rd_wr_addr_wb;
    logic [31:0]          rd_wr_data_wb;
    logic                 lsu_en_wb;
    lsu_op_e              lsu_op_wb;
    logic [31:0]          lsu_rdata_wb;
    logic                 lsu_valid_wb;
    logic                 lsu_err_wb;
    logic                 exc_taken_wb;
    logic [31:0]          pc_wb;
    logic                 ready_wb;

    logic                 rf_we;
    logic [4:0]           rf_waddr;
    logic [31:0]          rf_wdata;
    logic [TAG_WIDTH-1:0] rf_wtag;
    logic                 forward_wb_en;
    logic [TAG_WIDTH-1:0] forward_wb_tag;
    logic [4:0]           forward_wb_addr;
    logic [31:0]          forward_wb_wdata;
    logic                 clr_dirty_wb_en;
    logic [4:0]           clr_dirty_wb_addr;
    logic                 lsu_exc_valid;
    logic [31:0]          lsu_exc_pc;
    logic                 lsu_exc_store;
    logic                 retire_valid;
    logic [INSTRET_W-1:0] instret;

    modport slave (
        input  rd_wr_en_wb, rd_wr_tag_wb, rd_wr_addr_wb, rd_wr_data_wb,
               lsu_en_wb, lsu_op_wb, lsu_rdata_wb, lsu_valid_wb, lsu_err_wb,
               exc_taken_wb, pc_wb,
        output ready_wb, rf_we, rf_waddr, rf_wdata, rf_wtag,
               forward_wb_en, forward_wb_tag, forward_wb_addr, forward_wb_wdata,
               clr_dirty_wb_en, clr_dirty_wb_addr,
               lsu_exc_valid, lsu_exc_pc, lsu_exc_store, retire_valid, instret
    );

    modport master (
        output rd_wr_en_wb, rd_wr_tag_wb, rd_wr_addr_wb, rd_wr_data_wb,
               lsu_en_wb, lsu_op_wb, lsu_rdata_wb, lsu_valid_wb, lsu_err_wb,
               exc_taken_wb, pc_wb,
        input  ready_wb, rf_we, rf_waddr, rf_wdata, rf_wtag,
               forward_wb_en, forward_wb_tag, forward_wb_addr, forward_wb_wdata,
               clr_dirty_wb_en, clr_dirty_wb_addr,
               lsu_exc_valid, lsu_exc_pc, lsu_exc_store, retire_valid, instret
    );
endinterface

// File: rtl/wb_stage.sv
// Write-back stage: commits ALU/load results to the register file, holds the
// instruction context while a load/store response is pending, and counts retires.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int TAG_WIDTH = 4,
    parameter int INSTRET_W = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    wb_stage_if.slave   wb
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    typedef struct packed {
        logic                 rd_wr_en;
        logic [TAG_WIDTH-1:0] tag;
        logic [4:0]           addr;
        lsu_op_e              op;
        logic [31:0]          pc;
    } ctx_t;

    state_e               state_q, state_d;
    ctx_t                 ctx_q, ctx_d;
    ctx_t                 cur;
    logic                 exc_valid_q, exc_valid_d;
    logic [31:0]          exc_pc_q, exc_pc_d;
    logic                 exc_store_q, exc_store_d;
    logic [INSTRET_W-1:0] instret_q;

    logic                 occ;
    logic                 complete;
    logic                 ready;
    logic                 rf_we;
    logic [4:0]           rf_waddr;
    logic [31:0]          rf_wdata;
    logic [TAG_WIDTH-1:0] rf_wtag;
    logic                 clr_en;
    logic [4:0]           clr_addr;
    logic                 retire;

    assign occ = wb.rd_wr_en_wb | wb.lsu_en_wb | wb.exc_taken_wb;

    // Pick which context drives this cycle's completion: live inputs in IDLE,
    // captured regs in WAIT (upstream may have flushed its registers by then).
    always_comb begin
        state_d  = state_q;
        ctx_d    = ctx_q;
        ready    = 1'b1;
        complete = 1'b0;
        cur      = ctx_q;
        case (state_q)
            IDLE: begin
                if (occ && !wb.exc_taken_wb && wb.lsu_en_wb) begin
                    cur.rd_wr_en = wb.rd_wr_en_wb;
                    cur.tag      = wb.rd_wr_tag_wb;
                    cur.addr     = wb.rd_wr_addr_wb;
                    cur.op       = wb.lsu_op_wb;
                    cur.pc       = wb.pc_wb;
                    if (wb.lsu_valid_wb) begin
                        complete = 1'b1;
                    end else begin
                        ready   = 1'b0;
                        ctx_d   = cur;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                ready = wb.lsu_valid_wb;
                if (wb.lsu_valid_wb) begin
                    complete = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rf_we       = 1'b0;
        rf_waddr    = '0;
        rf_wdata    = '0;
        rf_wtag     = '0;
        clr_en      = 1'b0;
        clr_addr    = '0;
        retire      = 1'b0;
        exc_valid_d = 1'b0;
        exc_pc_d    = exc_pc_q;
        exc_store_d = exc_store_q;
        if (state_q == IDLE && occ && !wb.exc_taken_wb && !wb.lsu_en_wb) begin
            retire = 1'b1;
            if (wb.rd_wr_en_wb) begin
                rf_we    = 1'b1;
                rf_waddr = wb.rd_wr_addr_wb;
                rf_wdata = wb.rd_wr_data_wb;
                rf_wtag  = wb.rd_wr_tag_wb;
            end
        end else if (complete) begin
            if (wb.lsu_err_wb) begin
                exc_valid_d = 1'b1;
                exc_pc_d    = cur.pc;
                exc_store_d = (cur.op == LSU_OP_ST);
                // A failed load never writes rd, so its dirty bit must be released here.
                if (cur.op == LSU_OP_LD && cur.rd_wr_en) begin
                    clr_en   = 1'b1;
                    clr_addr = cur.addr;
                end
            end else begin
                retire = 1'b1;
                if (cur.op == LSU_OP_LD && cur.rd_wr_en) begin
                    rf_we    = 1'b1;
                    rf_waddr = cur.addr;
                    rf_wdata = wb.lsu_rdata_wb;
                    rf_wtag  = cur.tag;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctx_q       <= '0;
            exc_valid_q <= 1'b0;
            exc_pc_q    <= '0;
            exc_store_q <= 1'b0;
            instret_q   <= '0;
        end else begin
            ctx_q       <= ctx_d;
            exc_valid_q <= exc_valid_d;
            exc_pc_q    <= exc_pc_d;
            exc_store_q <= exc_store_d;
            if (retire) instret_q <= instret_q + 1'b1;
        end
    end

    assign wb.ready_wb          = ready;
    assign wb.rf_we             = rf_we;
    assign wb.rf_waddr          = rf_waddr;
    assign wb.rf_wdata          = rf_wdata;
    assign wb.rf_wtag           = rf_wtag;
    // x0 writes still reach the RF (it drops them) but must never be forwarded.
    assign wb.forward_wb_en     = rf_we && (rf_waddr != 5'd0);
    assign wb.forward_wb_tag    = rf_wtag;
    assign wb.forward_wb_addr   = rf_waddr;
    assign wb.forward_wb_wdata  = rf_wdata;
    assign wb.clr_dirty_wb_en   = clr_en;
    assign wb.clr_dirty_wb_addr = clr_addr;
    assign wb.lsu_exc_valid     = exc_valid_q;
    assign wb.lsu_exc_pc        = exc_pc_q;
    assign wb.lsu_exc_store     = exc_store_q;
    assign wb.retire_valid      = retire;
    assign wb.instret           = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: ALU, load/store wait, flush, bus error, reset and wrap.
module tb_wb_stage;
    import wb_stage_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    wb_stage_if #(.TAG_WIDTH(4), .INSTRET_W(64)) w ();
    wb_stage_if #(.TAG_WIDTH(4), .INSTRET_W(2))  w2 ();

    wb_stage #(.TAG_WIDTH(4), .INSTRET_W(64)) dut (.clk(clk), .reset_n(reset_n), .wb(w));
    wb_stage #(.TAG_WIDTH(4), .INSTRET_W(2))  dut2 (.clk(clk), .reset_n(reset_n), .wb(w2));

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        w.rd_wr_en_wb = 0; w.rd_wr_tag_wb = 0; w.rd_wr_addr_wb = 0; w.rd_wr_data_wb = 0;
        w.lsu_en_wb = 0; w.lsu_op_wb = LSU_OP_LD; w.lsu_rdata_wb = 0; w.lsu_valid_wb = 0;
        w.lsu_err_wb = 0; w.exc_taken_wb = 0; w.pc_wb = 0;
    endtask

    task automatic load(input logic [4:0] rd, input logic [3:0] tag, input logic [31:0] pc);
        clr_in();
        w.rd_wr_en_wb = 1; w.rd_wr_addr_wb = rd; w.rd_wr_tag_wb = tag;
        w.lsu_en_wb = 1; w.lsu_op_wb = LSU_OP_LD; w.pc_wb = pc;
    endtask

    initial begin
        reset_n = 0;
        clr_in();
        w2.rd_wr_en_wb = 0; w2.rd_wr_tag_wb = 0; w2.rd_wr_addr_wb = 0; w2.rd_wr_data_wb = 0;
        w2.lsu_en_wb = 0; w2.lsu_op_wb = LSU_OP_LD; w2.lsu_rdata_wb = 0; w2.lsu_valid_wb = 0;
        w2.lsu_err_wb = 0; w2.exc_taken_wb = 0; w2.pc_wb = 0;

        @(negedge clk);
        chk("rst_ready", w.ready_wb, 1);
        chk("rst_rf_we", w.rf_we, 0);
        chk("rst_instret", w.instret, 0);
        chk("rst_exc", w.lsu_exc_valid, 0);
        chk("rst_exc_pc", w.lsu_exc_pc, 0);
        next();
        reset_n = 1;

        // ALU write
        next();
        w.rd_wr_en_wb = 1; w.rd_wr_addr_wb = 5; w.rd_wr_data_wb = 32'h1234; w.rd_wr_tag_wb = 3;
        @(negedge clk);
        chk("alu_we", w.rf_we, 1);
        chk("alu_addr", w.rf_waddr, 5);
        chk("alu_data", w.rf_wdata, 32'h1234);
        chk("alu_tag", w.rf_wtag, 3);
        chk("alu_fwd_en", w.forward_wb_en, 1);
        chk("alu_fwd_data", w.forward_wb_wdata, 32'h1234);
        chk("alu_ready", w.ready_wb, 1);
        chk("alu_retire", w.retire_valid, 1);
        chk("alu_instret0", w.instret, 0);
        next();
        clr_in();
        @(negedge clk);
        chk("alu_instret1", w.instret, 1);

        // Load x7, response on the third cycle, inputs held
        next();
        load(7, 2, 32'h40);
        @(negedge clk);
        chk("ld_ready_a", w.ready_wb, 0);
        chk("ld_we_a", w.rf_we, 0);
        next();
        @(negedge clk);
        chk("ld_ready_b", w.ready_wb, 0);
        chk("ld_we_b", w.rf_we, 0);
        next();
        w.lsu_valid_wb = 1; w.lsu_rdata_wb = 32'hDEADBEEF;
        @(negedge clk);
        chk("ld_ready_c", w.ready_wb, 1);
        chk("ld_we_c", w.rf_we, 1);
        chk("ld_addr", w.rf_waddr, 7);
        chk("ld_data", w.rf_wdata, 32'hDEADBEEF);
        chk("ld_tag", w.rf_wtag, 2);
        chk("ld_retire", w.retire_valid, 1);
        next();
        clr_in();
        @(negedge clk);
        chk("ld_instret", w.instret, 2);
        chk("ld_idle_ready", w.ready_wb, 1);

        // Load x7 with upstream flush during the wait
        next();
        load(7, 5, 32'h44);
        @(negedge clk);
        chk("fl_ready_a", w.ready_wb, 0);
        next();
        clr_in();
        @(negedge clk);
        chk("fl_ready_b", w.ready_wb, 0);
        chk("fl_we_b", w.rf_we, 0);
        next();
        w.lsu_valid_wb = 1; w.lsu_rdata_wb = 32'h0BADF00D;
        @(negedge clk);
        chk("fl_we", w.rf_we, 1);
        chk("fl_addr", w.rf_waddr, 7);
        chk("fl_tag", w.rf_wtag, 5);
        chk("fl_data", w.rf_wdata, 32'h0BADF00D);
        next();
        clr_in();
        @(negedge clk);
        chk("fl_instret", w.instret, 3);

        // Load x9 faults
        next();
        load(9, 1, 32'h80);
        @(negedge clk);
        chk("er_ready_a", w.ready_wb, 0);
        next();
        w.lsu_valid_wb = 1; w.lsu_err_wb = 1;
        @(negedge clk);
        chk("er_clr_en", w.clr_dirty_wb_en, 1);
        chk("er_clr_addr", w.clr_dirty_wb_addr, 9);
        chk("er_we", w.rf_we, 0);
        chk("er_retire", w.retire_valid, 0);
        chk("er_exc_early", w.lsu_exc_valid, 0);
        next();
        clr_in();
        @(negedge clk);
        chk("er_exc", w.lsu_exc_valid, 1);
        chk("er_exc_pc", w.lsu_exc_pc, 32'h80);
        chk("er_exc_store", w.lsu_exc_store, 0);
        chk("er_instret", w.instret, 3);
        chk("er_clr_gone", w.clr_dirty_wb_en, 0);
        next();
        @(negedge clk);
        chk("er_exc_pulse", w.lsu_exc_valid, 0);

        // Store with same-cycle response
        next();
        w.lsu_en_wb = 1; w.lsu_op_wb = LSU_OP_ST; w.lsu_valid_wb = 1; w.pc_wb = 32'h90;
        @(negedge clk);
        chk("st_ready", w.ready_wb, 1);
        chk("st_retire", w.retire_valid, 1);
        chk("st_we", w.rf_we, 0);
        next();
        clr_in();
        @(negedge clk);
        chk("st_instret", w.instret, 4);
        chk("st_no_wait", w.ready_wb, 1);

        // Trapped load/store: no wait, no retire
        next();
        load(4, 1, 32'hA0);
        w.exc_taken_wb = 1;
        @(negedge clk);
        chk("tr_ready", w.ready_wb, 1);
        chk("tr_retire", w.retire_valid, 0);
        chk("tr_we", w.rf_we, 0);
        next();
        clr_in();
        @(negedge clk);
        chk("tr_no_wait", w.ready_wb, 1);
        chk("tr_instret", w.instret, 4);

        // Stray response while idle is ignored
        next();
        w.lsu_valid_wb = 1; w.lsu_rdata_wb = 32'h55;
        @(negedge clk);
        chk("sp_we", w.rf_we, 0);
        chk("sp_retire", w.retire_valid, 0);
        next();
        clr_in();
        @(negedge clk);
        chk("sp_ready", w.ready_wb, 1);

        // x0 write: RF sees it, forwarding does not
        next();
        w.rd_wr_en_wb = 1; w.rd_wr_addr_wb = 0; w.rd_wr_data_wb = 32'h77;
        @(negedge clk);
        chk("x0_we", w.rf_we, 1);
        chk("x0_fwd", w.forward_wb_en, 0);
        next();
        clr_in();
        @(negedge clk);
        chk("x0_instret", w.instret, 5);

        // Reset during WAIT drops the pending response
        next();
        load(3, 6, 32'hB0);
        @(negedge clk);
        chk("rw_ready_a", w.ready_wb, 0);
        next();
        clr_in();
        reset_n = 0;
        @(negedge clk);
        chk("rw_ready", w.ready_wb, 1);
        chk("rw_instret", w.instret, 0);
        chk("rw_exc", w.lsu_exc_valid, 0);
        chk("rw_exc_pc", w.lsu_exc_pc, 0);
        next();
        reset_n = 1;
        w.lsu_valid_wb = 1; w.lsu_rdata_wb = 32'hCAFE;
        @(negedge clk);
        chk("rw_we", w.rf_we, 0);
        chk("rw_retire", w.retire_valid, 0);
        chk("rw_ready_r", w.ready_wb, 1);
        next();
        clr_in();

        // Counter wrap on the 2-bit instance
        w2.rd_wr_en_wb = 1; w2.rd_wr_addr_wb = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("wr_full", w2.instret, 3);
        next();
        w2.rd_wr_en_wb = 0;
        @(negedge clk);
        chk("wr_zero", w2.instret, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
